ad7606_volt_sched: RTL and testbench

//  Per-frame scheduler for AD7606 voltage conversion. Buffers one frame of NCH raw 16-bit
//  two's-complement samples, then runs them one channel at a time, in order, through a single

---
 rtl/ad7606_volt_sched_pkg.sv | 15 +
 rtl/ad7606_volt_sched_if.sv | 21 ++
 rtl/ad7606_volt_sched_pipe.sv | 46 ++++
 rtl/ad7606_volt_sched.sv | 156 +++++++++++++++
 tb/tb_ad7606_volt_sched.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ad7606_volt_sched_pkg.sv
// Shared constants and FSM state encoding for the AD7606 voltage scheduler.
package ad7606_pkg;
    localparam int         NCH_MAX     = 8;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam int         SCALE_SHIFT = 15;
    localparam int         PIPE_LAT    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;
endpackage

// File: rtl/ad7606_volt_sched_if.sv
// Raw-sample input and result stream of the AD7606 voltage scheduler.
interface ad7606_volt_sched_if;
    logic        s_valid;
    logic [2:0]  s_ch;
    logic [15:0] s_data;
    logic        s_last;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_ch;
    logic [15:0] out_mag;
    logic [7:0]  out_sign;

    modport master (
        output s_valid, s_ch, s_data, s_last, out_ready,
        input  out_valid, out_ch, out_mag, out_sign
    );
    modport slave (
        input  s_valid, s_ch, s_data, s_last, out_ready,
        output out_valid, out_ch, out_mag, out_sign
    );
endinterface

// File: rtl/ad7606_volt_sched_pipe.sv
// Three-stage sign/magnitude/scale pipeline: |code|*FULL_SCALE >> 15, no stall.
module volt_scale_pipe
    import ad7606_pkg::*;
#(
    parameter int FULL_SCALE = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        out_valid,
    output logic [15:0] out_mag,
    output logic [7:0]  out_sign
);
    localparam logic [31:0] SCALE = 32'(FULL_SCALE);

    logic [PIPE_LAT:1] r_vld_pipe;
    logic [PIPE_LAT:1] r_neg_pipe;
    logic [16:0]       r_mag1;
    logic [31:0]       r_prod;
    logic [15:0]       r_mag3;
    logic [16:0]       w_mag;

    // 17 bits so that 16'h8000 becomes +32768 rather than wrapping
    assign w_mag = in_data[15] ? ({1'b0, ~in_data} + 17'd1) : {1'b0, in_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_neg_pipe <= '0;
            r_mag1     <= '0;
            r_prod     <= '0;
            r_mag3     <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[PIPE_LAT-1:1], in_valid};
            r_neg_pipe <= {r_neg_pipe[PIPE_LAT-1:1], in_data[15]};
            r_mag1     <= w_mag;
            r_prod     <= {15'd0, r_mag1} * SCALE;
            r_mag3     <= 16'(r_prod >> SCALE_SHIFT);
        end
    end

    assign out_valid = r_vld_pipe[PIPE_LAT];
    assign out_mag   = r_mag3;
    assign out_sign  = r_neg_pipe[PIPE_LAT] ? ASCII_MINUS : ASCII_PLUS;
endmodule

// File: rtl/ad7606_volt_sched.sv
// Per-frame AD7606 conversion scheduler: buffers a frame, then runs channels through one pipe.
// Optional VOLT_PEAK_EN adds peak_mag/peak_ch tracking of the largest result per run.
module ad7606_volt_sched
    import ad7606_pkg::*;
#(
    parameter int NCH        = 8,
    parameter int FULL_SCALE = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ad7606_volt_sched_if.slave     bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun,
`ifdef VOLT_PEAK_EN
    output logic [15:0]            peak_mag,
    output logic [2:0]             peak_ch,
`endif
    input  logic                   clr_ovr
);
    localparam logic [2:0] LAST_CH = 3'(NCH - 1);

    state_t               r_state, w_next;
    logic [2:0]           r_ch;
    logic [NCH-1:0][15:0] r_buf;
    logic [15:0]          w_sel;
    logic                 w_start, w_issue, w_cap, w_accept, w_last;
    logic                 w_pv;
    logic [15:0]          w_pmag;
    logic [7:0]           w_psign;
    logic                 r_out_valid;
    logic [2:0]           r_out_ch;
    logic [15:0]          r_out_mag;
    logic [7:0]           r_out_sign;
    logic                 r_frame_done;
    logic                 r_overrun;

    assign busy   = (r_state != IDLE);
    assign w_last = (r_ch == LAST_CH);

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NCH; i++)
            if (r_ch == 3'(i)) w_sel = r_buf[i];
    end

    // Samples only land while idle; out-of-range channels match no entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
        end else if (r_state == IDLE && bus.s_valid) begin
            for (int i = 0; i < NCH; i++)
                if (bus.s_ch == 3'(i)) r_buf[i] <= bus.s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_issue  = 1'b0;
        w_cap    = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            IDLE: if (bus.s_valid && bus.s_last) begin
                w_start = 1'b1;
                w_next  = ISSUE;
            end
            ISSUE: begin
                w_issue = 1'b1;
                w_next  = WAIT;
            end
            WAIT: if (w_pv) begin
                w_cap  = 1'b1;
                w_next = HOLD;
            end
            HOLD: if (bus.out_ready) begin
                w_accept = 1'b1;
                w_next   = w_last ? IDLE : ISSUE;
            end
            default: w_next = IDLE;
        endcase
    end

    volt_scale_pipe #(.FULL_SCALE(FULL_SCALE)) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (w_issue),
        .in_data  (w_sel),
        .out_valid(w_pv),
        .out_mag  (w_pmag),
        .out_sign (w_psign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch         <= '0;
            r_out_valid  <= 1'b0;
            r_out_ch     <= '0;
            r_out_mag    <= '0;
            r_out_sign   <= ASCII_PLUS;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_last;
            if (w_start)
                r_ch <= '0;
            else if (w_accept && !w_last)
                r_ch <= r_ch + 3'd1;
            if (w_cap) begin
                r_out_valid <= 1'b1;
                r_out_ch    <= r_ch;
                r_out_mag   <= w_pmag;
                r_out_sign  <= w_psign;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
            // A new overrun event outranks a simultaneous clear
            if (bus.s_valid && busy) r_overrun <= 1'b1;
            else if (clr_ovr)        r_overrun <= 1'b0;
        end
    end

`ifdef VOLT_PEAK_EN
    logic [15:0] r_peak_mag;
    logic [2:0]  r_peak_ch;

    // Strict compare: channels arrive in order, so ties keep the lower one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak_mag <= '0;
            r_peak_ch  <= '0;
        end else if (w_start) begin
            r_peak_mag <= '0;
            r_peak_ch  <= '0;
        end else if (w_accept && r_out_mag > r_peak_mag) begin
            r_peak_mag <= r_out_mag;
            r_peak_ch  <= r_out_ch;
        end
    end

    assign peak_mag = r_peak_mag;
    assign peak_ch  = r_peak_ch;
`endif

    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_mag   = r_out_mag;
    assign bus.out_sign  = r_out_sign;
    assign frame_done    = r_frame_done;
    assign overrun       = r_overrun;
endmodule

// File: tb/tb_ad7606_volt_sched.sv
// Directed bench for ad7606_volt_sched: table-driven frames plus stall/overrun/reset/NCH=4 sequences.
module tb_ad7606_volt_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        d_valid = 1'b0, d_last = 1'b0, d_ready = 1'b0, d_clr = 1'b0, sel4 = 1'b0;
    logic [2:0]  d_ch = '0;
    logic [15:0] d_data = '0;

    always #5 clk = ~clk;

    ad7606_volt_sched_if if8();
    ad7606_volt_sched_if if4();

    assign if8.s_valid   = d_valid & ~sel4;
    assign if8.s_last    = d_last & ~sel4;
    assign if8.s_ch      = d_ch;
    assign if8.s_data    = d_data;
    assign if8.out_ready = d_ready & ~sel4;
    assign if4.s_valid   = d_valid & sel4;
    assign if4.s_last    = d_last & sel4;
    assign if4.s_ch      = d_ch;
    assign if4.s_data    = d_data;
    assign if4.out_ready = d_ready & sel4;

    logic busy8, fd8, ovr8, busy4, fd4, ovr4;
`ifdef VOLT_PEAK_EN
    logic [15:0] pk8, pk4;
    logic [2:0]  pc8, pc4;
`endif

    ad7606_volt_sched #(.NCH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8),
        .busy(busy8), .frame_done(fd8), .overrun(ovr8),
`ifdef VOLT_PEAK_EN
        .peak_mag(pk8), .peak_ch(pc8),
`endif
        .clr_ovr(d_clr)
    );

    ad7606_volt_sched #(.NCH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4),
        .busy(busy4), .frame_done(fd4), .overrun(ovr4),
`ifdef VOLT_PEAK_EN
        .peak_mag(pk4), .peak_ch(pc4),
`endif
        .clr_ovr(d_clr)
    );

    logic        o_valid, o_busy, o_fd, o_ovr;
    logic [2:0]  o_ch;
    logic [15:0] o_mag;
    logic [7:0]  o_sign;
    assign o_valid = sel4 ? if4.out_valid : if8.out_valid;
    assign o_ch    = sel4 ? if4.out_ch    : if8.out_ch;
    assign o_mag   = sel4 ? if4.out_mag   : if8.out_mag;
    assign o_sign  = sel4 ? if4.out_sign  : if8.out_sign;
    assign o_busy  = sel4 ? busy4 : busy8;
    assign o_fd    = sel4 ? fd4   : fd8;
    assign o_ovr   = sel4 ? ovr4  : ovr8;

    typedef struct {
        logic [15:0] code;
        logic [15:0] mag;
        logic [7:0]  sign;
    } vec_t;

    localparam logic [7:0] PL = 8'h2B;
    localparam logic [7:0] MI = 8'h2D;

    vec_t tabs [3][8];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic [15:0] c, input logic [15:0] m, input logic [7:0] s);
        vec_t v;
        v.code = c; v.mag = m; v.sign = s;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives samples 0..n-1; the last one (with s_last) is left on the bus
    task automatic send_frame(input int n, input int t);
        for (int k = 0; k < n; k++) begin
            d_valid = 1'b1;
            d_ch    = 3'(k);
            d_data  = tabs[t][k].code;
            d_last  = (k == n - 1);
            if (k < n - 1) tick();
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!o_valid && n < 40) begin
            tick();
            d_valid = 1'b0;
            d_last  = 1'b0;
            n++;
        end
        if (!o_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic collect(input int t, input int nres, input bit chk_lat, input bit fin);
        int n;
        for (int k = 0; k < nres; k++) begin
            wait_valid(n);
            if (chk_lat) chk($sformatf("t%0d_lat%0d", t, k), (k == 0) ? n : n + 1, 5);
            chk($sformatf("t%0d_ch%0d", t, k), o_ch, k);
            chk($sformatf("t%0d_mag%0d", t, k), o_mag, tabs[t][k].mag);
            chk($sformatf("t%0d_sign%0d", t, k), o_sign, tabs[t][k].sign);
            tick();
        end
        if (fin) begin
            chk($sformatf("t%0d_frame_done", t), o_fd, 1);
            chk($sformatf("t%0d_idle", t), o_busy, 0);
            tick();
            chk($sformatf("t%0d_frame_done_pulse", t), o_fd, 0);
        end
    endtask

    initial begin
        int n, bad;
        logic [15:0] hold_mag;

        tabs[0][0] = mk(16'h4000, 16'd25000, PL);
        tabs[0][1] = mk(16'hC000, 16'd25000, MI);
        tabs[0][2] = mk(16'h0001, 16'd1,     PL);
        tabs[0][3] = mk(16'hFFFF, 16'd1,     MI);
        tabs[0][4] = mk(16'h7FFF, 16'd49998, PL);
        tabs[0][5] = mk(16'h8000, 16'd50000, MI);
        tabs[0][6] = mk(16'h0000, 16'd0,     PL);
        tabs[0][7] = mk(16'h2000, 16'd12500, PL);
        tabs[1][0] = mk(16'hFFFE, 16'd3,     MI);
        tabs[1][1] = mk(16'h1000, 16'd6250,  PL);
        tabs[1][2] = mk(16'h8001, 16'd49998, MI);
        tabs[1][3] = mk(16'h0100, 16'd390,   PL);
        tabs[1][4] = mk(16'h0003, 16'd4,     PL);
        tabs[1][5] = mk(16'hF000, 16'd6250,  MI);
        tabs[1][6] = mk(16'h0010, 16'd24,    PL);
        tabs[1][7] = mk(16'h3000, 16'd18750, PL);
        for (int k = 0; k < 8; k++) tabs[2][k] = mk(16'h0000, 16'd0, PL);

        // Reset values
        repeat (2) tick();
        chk("rst_out_valid", o_valid, 0);
        chk("rst_out_mag", o_mag, 0);
        chk("rst_out_sign", o_sign, 8'h2B);
        chk("rst_busy", o_busy, 0);
        chk("rst_frame_done", o_fd, 0);
        chk("rst_overrun", o_ovr, 0);
        rst_n = 1'b1;
        tick();

        // Reference frame, out_ready held high
        d_ready = 1'b1;
        send_frame(8, 0);
        collect(0, 8, 1, 1);
`ifdef VOLT_PEAK_EN
        chk("peak_mag_frame0", pk8, 50000);
        chk("peak_ch_frame0", pc8, 5);
`endif

        // All-zero frame
        send_frame(8, 2);
        collect(2, 8, 1, 1);
`ifdef VOLT_PEAK_EN
        chk("peak_mag_zero", pk8, 0);
        chk("peak_ch_zero", pc8, 0);
`endif

        // Backpressure: ch2 stalled for 10 cycles
        d_ready = 1'b0;
        send_frame(8, 0);
        for (int k = 0; k < 8; k++) begin
            wait_valid(n);
            if (k == 3) chk("stall_resume_lat", n + 1, 5);
            chk($sformatf("stall_ch%0d", k), o_ch, k);
            chk($sformatf("stall_mag%0d", k), o_mag, tabs[0][k].mag);
            chk($sformatf("stall_sign%0d", k), o_sign, tabs[0][k].sign);
            if (k == 2) begin
                bad = 0;
                hold_mag = o_mag;
                repeat (10) begin
                    tick();
                    if (!o_valid || o_ch != 3'd2 || o_mag != hold_mag || o_sign != tabs[0][2].sign) bad++;
                end
                chk("stall_hold_stable", bad, 0);
            end
            d_ready = 1'b1;
            tick();
            d_ready = 1'b0;
        end
        chk("stall_frame_done", o_fd, 1);
        tick();
        chk("stall_frame_done_pulse", o_fd, 0);

        // Overrun while a run is stalled at ch0
        send_frame(8, 0);
        tick();
        d_valid = 1'b0; d_last = 1'b0;
        repeat (8) tick();
        chk("ovr_busy", o_busy, 1);
        d_valid = 1'b1; d_ch = 3'd0; d_data = 16'h1234;
        tick();
        d_valid = 1'b0;
        chk("ovr_set", o_ovr, 1);
        d_clr = 1'b1;
        tick();
        d_clr = 1'b0;
        chk("ovr_clear", o_ovr, 0);
        d_valid = 1'b1; d_clr = 1'b1;
        tick();
        d_valid = 1'b0; d_clr = 1'b0;
        chk("ovr_set_beats_clr", o_ovr, 1);
        d_ready = 1'b1;
        collect(0, 8, 0, 1);
        d_clr = 1'b1;
        tick();
        d_clr = 1'b0;
        chk("ovr_cleared_idle", o_ovr, 0);
        // Only ch7 rewritten; ch0 must still hold 4000h, not the dropped 1234h
        d_valid = 1'b1; d_ch = 3'd7; d_data = 16'h2000; d_last = 1'b1;
        collect(0, 8, 1, 1);

        // Async reset while ch4 is in WAIT
        send_frame(8, 0);
        collect(0, 4, 1, 0);
        tick();
        chk("prerst_busy", o_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", o_valid, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_out_mag", o_mag, 0);
        chk("midrst_out_ch", o_ch, 0);
        chk("midrst_out_sign", o_sign, 8'h2B);
        chk("midrst_frame_done", o_fd, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            tick();
            if (o_valid || o_fd || o_busy) bad++;
        end
        chk("postrst_quiet", bad, 0);
        send_frame(8, 1);
        collect(1, 8, 1, 1);

        // NCH=4 instance
        sel4 = 1'b1;
        send_frame(4, 0);
        collect(0, 4, 1, 1);
        bad = 0;
        repeat (10) begin
            tick();
            if (o_valid || o_busy) bad++;
        end
        chk("nch4_no_extra", bad, 0);
        sel4 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
